// File: rtl/helix4_world_model.sv
// helix4_world_model: closed-loop world stage. Buffers 24-bit actions in a
// small FIFO, folds each one into a running world state, and presents the
// resulting feedback word on the world port after a fixed latency.
module helix4_world_model #(
  parameter int unsigned ACTION_W = 24,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LATENCY  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      action_valid,
  output logic                      action_ready,
  input  logic [ACTION_W-1:0]       action_data,
  output logic                      world_valid,
  input  logic                      world_ready,
  output logic [ACTION_W-1:0]       world_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [CNT_W-1:0]          resp_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [7:0]       LAT_INIT = 8'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [ACTION_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic [1:0]          r_state;
  logic [7:0]          r_cnt;
  logic [ACTION_W-1:0] r_wstate;
  logic [ACTION_W-1:0] r_out;
  logic [CNT_W-1:0]    r_resp;

  logic                w_push;
  logic                w_pop;
  logic [ACTION_W-1:0] w_head;
  logic [ACTION_W:0]   w_sum;
  logic [ACTION_W-1:0] w_result;

  // Ready comes from the registered level only, so a same-cycle pop never
  // frees a slot early and there is no path from any input to an output.
  assign w_push   = action_valid && (r_level != FULL_LVL);
  assign w_pop    = (r_state == S_IDLE) && (r_level != '0);
  assign w_head   = r_mem[r_rptr];
  // One extra bit keeps the sum exact; halving brings it back into range.
  assign w_sum    = {1'b0, w_head} + {1'b0, r_wstate};
  assign w_result = w_sum[ACTION_W:1];

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= action_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Processing FSM: pop and compute in IDLE, count down in WAIT, hold in EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wstate <= '0;
      r_out    <= '0;
      r_resp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_wstate <= w_result;
            r_out    <= w_result;
            if (LATENCY == 0) begin
              r_state <= S_EMIT;
            end else begin
              r_cnt   <= LAT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd1) begin
            r_state <= S_EMIT;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_EMIT: begin
          if (world_ready) begin
            r_resp  <= r_resp + CNT_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign action_ready = (r_level != FULL_LVL);
  assign world_valid  = (r_state == S_EMIT);
  assign world_data   = r_out;
  assign fifo_level   = r_level;
  assign resp_count   = r_resp;

endmodule

// File: tb/tb_helix4_world_model.sv
// Self-checking bench for helix4_world_model: directed table, corner-case
// sequences and a randomized phase scored against a behavioural model.
module tb_helix4_world_model;

  logic        clk;
  logic        rst_n;
  // DUT with default latency
  logic        a_valid, a_ready, w_valid, w_ready;
  logic [23:0] a_data, w_data;
  logic [2:0]  level;
  logic [15:0] resp;
  // DUT with zero latency
  logic        b_valid, b_ready, bw_valid, bw_ready;
  logic [23:0] b_data, bw_data;
  logic [2:0]  b_level;
  logic [15:0] b_resp;

  helix4_world_model dut (
    .clk(clk), .rst_n(rst_n),
    .action_valid(a_valid), .action_ready(a_ready), .action_data(a_data),
    .world_valid(w_valid), .world_ready(w_ready), .world_data(w_data),
    .fifo_level(level), .resp_count(resp)
  );

  helix4_world_model #(.LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .action_valid(b_valid), .action_ready(b_ready), .action_data(b_data),
    .world_valid(bw_valid), .world_ready(bw_ready), .world_data(bw_data),
    .fifo_level(b_level), .resp_count(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: each accepted action a yields floor((a + w) / 2),
  // which also becomes the new w. Results come out in acceptance order.
  int unsigned  m_ws;
  int unsigned  exp_q[$];
  int unsigned  m_resp;
  logic         hold_pending;
  logic [23:0]  held_data;

  always @(negedge rst_n) begin
    exp_q.delete();
    m_ws         = 0;
    m_resp       = 0;
    hold_pending = 1'b0;
  end

  // Scoreboard sampled on the edge itself (pre-edge values).
  always @(posedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        chk("stall_hold_valid", {31'd0, w_valid}, 32'd1);
        chk("stall_hold_data", {8'd0, w_data}, {8'd0, held_data});
      end
      hold_pending = w_valid && !w_ready;
      held_data    = w_data;
      if (w_valid && w_ready) begin
        m_resp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", {8'd0, w_data}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", {8'd0, w_data}, exp_q.pop_front());
        end
      end
      if (a_valid && a_ready) begin
        m_ws = (int'(a_data) + m_ws) / 2;
        exp_q.push_back(m_ws);
      end
    end
  end

  typedef struct {
    logic [23:0] data;
    logic [23:0] expd;
  } vec_t;

  vec_t chain[3];

  // Send one action, measure acceptance-to-valid latency, check the word.
  task automatic send_lat(input logic [23:0] d, input int lat, input logic [23:0] expd);
    logic r;
    int   k;
    bit   done;
    a_valid = 1'b1;
    a_data  = d;
    done    = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      r = a_ready;
      tick();
      if (r) done = 1;
    end
    a_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    k = 0;
    while (!w_valid && k < 40) begin
      tick();
      k++;
    end
    chk("latency", k, lat + 1);
    chk("world_data", {8'd0, w_data}, {8'd0, expd});
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || w_valid) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [23:0] fd [6];
    logic        r;
    int          acc;
    int          idx;
    logic [23:0] d0;
    int unsigned e;

    chain[0] = '{data: 24'd50, expd: 24'd25};
    chain[1] = '{data: 24'd30, expd: 24'd27};
    chain[2] = '{data: 24'd10, expd: 24'd18};

    a_valid = 0; a_data = 0; w_ready = 0;
    b_valid = 0; b_data = 0; bw_ready = 1;
    rst_n = 0;
    repeat (5) tick();
    chk("rst_action_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_world_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_world_data", {8'd0, w_data}, 32'd0);
    chk("rst_fifo_level", {29'd0, level}, 32'd0);
    chk("rst_resp_count", {16'd0, resp}, 32'd0);
    rst_n = 1;
    tick();

    // Basic chain with world_ready high.
    w_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send_lat(chain[i].data, 3, chain[i].expd);
      tick();
      chk("valid_drops_after_xfer", {31'd0, w_valid}, 32'd0);
    end
    chk("chain_resp_count", {16'd0, resp}, 32'd3);

    // Fill with back-pressure: 6 offered, 5 accepted.
    w_ready = 0;
    fd[0] = 24'd100; fd[1] = 24'd2000; fd[2] = 24'hFFFFFF;
    fd[3] = 24'hFFFFFE; fd[4] = 24'd7; fd[5] = 24'd12345;
    acc = 0; idx = 0;
    a_valid = 1; a_data = fd[0];
    for (int c = 0; c < 12; c++) begin
      r = a_ready;
      tick();
      if (r && a_valid) begin
        acc++;
        idx++;
        if (idx < 6) a_data = fd[idx];
        else a_valid = 0;
      end
    end
    chk("fill_acceptances", acc, 5);
    chk("fill_level", {29'd0, level}, 32'd4);
    chk("fill_ready_low", {31'd0, a_ready}, 32'd0);
    a_valid = 0;
    w_ready = 1;
    drain(100);
    chk("fill_resp_count", {16'd0, resp}, 32'd8);

    // Stall stability during EMIT.
    w_ready = 0;
    e = (1000 + m_ws) / 2;
    send_lat(24'd1000, 3, e[23:0]);
    d0 = w_data;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", {31'd0, w_valid}, 32'd1);
      chk("stall_data", {8'd0, w_data}, {8'd0, d0});
    end
    w_ready = 1;
    tick();
    chk("stall_single_xfer", {31'd0, w_valid}, 32'd0);
    chk("stall_resp_count", {16'd0, resp}, 32'd9);

    // Zero latency on the second instance.
    b_valid = 1; b_data = 24'd200;
    r = b_ready;
    tick();
    b_valid = 0;
    chk("zl_accepted", {31'd0, r}, 32'd1);
    tick();
    chk("zl_valid", {31'd0, bw_valid}, 32'd1);
    chk("zl_data", {8'd0, bw_data}, 32'd100);
    tick();
    chk("zl_valid_drop", {31'd0, bw_valid}, 32'd0);
    chk("zl_resp_count", {16'd0, b_resp}, 32'd1);

    // Mid-operation reset during WAIT with 2 actions queued.
    w_ready = 0;
    a_valid = 1;
    a_data = 24'd77; tick();
    a_data = 24'd99; tick();
    a_data = 24'd55; tick();
    a_valid = 0;
    chk("mid_level_setup", {29'd0, level}, 32'd2);
    chk("mid_in_wait", {31'd0, w_valid}, 32'd0);
    rst_n = 0;
    #1;
    chk("mid_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, w_valid}, 32'd0);
    chk("mid_rst_data", {8'd0, w_data}, 32'd0);
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_resp", {16'd0, resp}, 32'd0);
    tick();
    tick();
    rst_n = 1;
    tick();
    w_ready = 1;
    send_lat(24'd40, 3, 24'd20);
    tick();
    chk("post_rst_resp", {16'd0, resp}, 32'd1);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      a_valid = ($urandom_range(0, 1) == 1);
      a_data  = 24'($urandom);
      if ($urandom_range(0, 7) == 0) a_data = 24'hFFFFFF;
      w_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("ready_rule", {31'd0, a_ready}, {31'd0, (level != 3'd4)});
      tick();
    end
    a_valid = 0;
    w_ready = 1;
    drain(200);
    chk("rand_resp_count", {16'd0, resp}, {16'd0, m_resp[15:0]});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/helix4_world_model.md
# helix4_world_model

Closed-loop environment stage that sits directly downstream of the die's action port and upstream of its world-feedback port. It accepts 24-bit actions over a valid/ready handshake, buffers them in a small FIFO, and for each action computes a feedback word from a running world-state register. The feedback word is presented on the world port after a fixed, parameterised latency. This closes the action → world loop in simulation and on FPGA bring-up boards, so no hand-driven world stimulus is needed.

## Interface
Parameters:
- ACTION_W, 24: action and world data width.
- DEPTH, 4: action FIFO entries; power of two, ≥2.
- LATENCY, 3: processing cycles per action; range 0..255.
- CNT_W, 16: width of the response counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- action_valid  in  1  action from the die is valid.
- action_ready  out  1  FIFO can accept an action.
- action_data  in  ACTION_W  action payload.
- world_valid  out  1  feedback word valid.
- world_ready  in  1  die accepts the feedback word.
- world_data  out  ACTION_W  feedback payload.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- resp_count  out  CNT_W  number of completed world transfers; wraps modulo 2^CNT_W.

## Operation
- FIFO push on action_valid && action_ready. action_ready = (fifo_level != DEPTH) and is based only on the registered level. A pop in the same cycle does not raise action_ready.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head a. Compute r = (a + wstate) >> 1, using an ACTION_W+1-bit sum with no overflow, so r ≤ 2^ACTION_W−1. Write wstate ← r and out_reg ← r. If LATENCY==0, go to EMIT; else set cnt ← LATENCY and go to WAIT.
  - WAIT: if cnt==1, go to EMIT; else cnt ← cnt−1.
  - EMIT: world_valid=1 and world_data=out_reg, held stable. When world_ready is high, increment resp_count and return to IDLE.
- EMIT does not pop. The next pop happens at the earliest on the edge after the return to IDLE.
- Simultaneous push and pop: level is unchanged and both operations take effect.
- Pointers wrap modulo DEPTH.
- Reset (asynchronous, any time, including mid-WAIT or mid-EMIT):
  - FIFO empty, fifo_level=0.
  - action_ready=1 in reset.
  - FSM=IDLE, world_valid=0.
  - world_data=0, wstate=0, cnt=0, resp_count=0.
  - Any in-flight action is discarded.

## Timing
- All outputs are registered or derived from registered state only. There is no combinational path from world_ready or action_valid to any output.
- Latency, empty FIFO and FSM in IDLE: acceptance at edge E0, pop at E1, world_valid rises after edge E0+LATENCY+1.
- World handshake:
  - The world transfer completes on the edge where world_valid && world_ready.
  - world_valid is low from the following cycle for at least one cycle, because IDLE always intervenes.
- Sustained throughput: one action per LATENCY+2 cycles with world_ready tied high; back-pressure stalls this further.
- world_data changes only on the pop edge. It is stable throughout WAIT and EMIT.

## Test plan
- Reset check: hold rst_n=0 for 5 cycles. Require action_ready=1, world_valid=0, world_data=0, fifo_level=0, resp_count=0.
- Basic chain: send actions 50, 30, 10 one at a time with world_ready=1, LATENCY=3.
  - Require world_data of 25, 27, 18 in order.
  - Require world_valid to rise exactly 4 cycles after each acceptance edge.
  - Require resp_count=3 at the end.
- Fill and back-pressure: hold world_ready=0 and push 6 actions back-to-back with DEPTH=4.
  - Require action_ready to drop once fifo_level=4, and exactly 5 acceptances (4 in FIFO, 1 in FSM).
  - Release world_ready; require all 5 responses in order with no loss.
- Stall stability: hold world_ready=0 for 10 cycles during EMIT. Require world_valid and world_data constant, then a single transfer when world_ready is asserted.
- Zero latency: with LATENCY=0, send 200 into wstate=0. Require world_data=100 one cycle after acceptance.
- Mid-operation reset: assert rst_n=0 during WAIT with 2 actions queued.
  - Require all outputs back to reset values immediately (asynchronously).
  - After release, send 40; require a response of 20, proving wstate was cleared.
